// File: rtl/butch_i2s_sched.sv
// -----------------------------------------------------------------------------
// butch_i2s_sched
//   Sequencer/arbiter in front of the Butch I2S register port. On start it
//   programs the bit-clock divider and then the control word. It then streams
//   stereo frames from a local FIFO into the left/right transmit registers once
//   per word-select period. It also shares the single register write port with
//   CPU writes, giving the scheduler priority.
//
//   Optional feature: define BUTCH_I2S_SCHED_MUTE_EN so that a frame slot that
//   finds the FIFO empty writes 16'h0000 to left then right. Without it the
//   slot is skipped and the serialiser repeats its last sample. Either way the
//   sticky underrun flag is set.
//
// Ports
//   sys_clk, resetl       clock (rising edge), asynchronous active-low reset
//   start, stop           pulses: configure+stream / disable+flush
//   src_valid/src_data    stereo frame {left[15:0], right[15:0]} from source
//   src_ready             FIFO not full
//   cpu_wr/cpu_sel/cpu_din CPU register write (held until accepted)
//   cpu_busy              CPU write not accepted this cycle
//   wsout                 word select from I2S (asynchronous)
//   i2s_din, i2s1w..i2s4w write data and strobes (left, right, divider, control)
//   level                 FIFO occupancy
//   underrun              sticky: frame slot found FIFO empty
//   busy                  sequencer not idle
// -----------------------------------------------------------------------------
module butch_i2s_sched #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [7:0]  DIV_DEF    = 8'h08,
   parameter logic [5:0]  CTRL_DEF   = 6'h05
) (
   input  logic                          sys_clk,
   input  logic                          resetl,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          src_valid,
   input  logic [31:0]                   src_data,
   output logic                          src_ready,
   input  logic                          cpu_wr,
   input  logic [1:0]                    cpu_sel,
   input  logic [15:0]                   cpu_din,
   output logic                          cpu_busy,
   input  logic                          wsout,
   output logic [15:0]                   i2s_din,
   output logic                          i2s1w,
   output logic                          i2s2w,
   output logic                          i2s3w,
   output logic                          i2s4w,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          underrun,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CFG_DIV = 3'd1,
      ST_CFG_CTL = 3'd2,
      ST_RUN     = 3'd3,
      ST_STOP    = 3'd4
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [31:0]     mem_r [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic            ws1_r, ws2_r, ws3_r;
   logic [3:0]      sw_r, sw_nxt_s;          // scheduler strobes, one-hot {ctl,div,right,left}
   logic [15:0]     sdin_r, sdin_nxt_s;
   logic [15:0]     right_r, right_nxt_s;    // right sample latched when the frame is popped
   logic            rpend_r, rpend_nxt_s;    // right write owed next cycle
   logic            slot_q_r, slot_q_nxt_s;  // one slot deferred behind a pending pair
   logic            underrun_r, under_set_s, under_clr_s;
   logic            pop_s, push_s, flush_s;
   logic            fifo_empty_s, fifo_full_s, slot_s, sched_act_s, cpu_acc_s;
   logic [31:0]     rd_data_s;

   assign fifo_empty_s = (level_r == {LW{1'b0}});
   assign fifo_full_s  = (level_r == LW'(FIFO_DEPTH));
   assign rd_data_s    = mem_r[rd_ptr_r];
   assign slot_s       = ws2_r & ~ws3_r;
   assign push_s       = src_valid & ~fifo_full_s & ~flush_s;

   // Word-select synchroniser; ws3 is the delayed copy for rising-edge detection.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         ws1_r <= 1'b0;
         ws2_r <= 1'b0;
         ws3_r <= 1'b0;
      end else begin
         ws1_r <= wsout;
         ws2_r <= ws1_r;
         ws3_r <= ws2_r;
      end
   end

   // Next-state and next-strobe decode; a strobe is registered on entry to the cycle it appears in.
   always_comb begin
      state_nxt_s  = state_r;
      sw_nxt_s     = 4'b0000;
      sdin_nxt_s   = 16'h0000;
      right_nxt_s  = right_r;
      rpend_nxt_s  = 1'b0;
      slot_q_nxt_s = 1'b0;
      under_set_s  = 1'b0;
      under_clr_s  = 1'b0;
      pop_s        = 1'b0;
      flush_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (stop) begin
               state_nxt_s = ST_IDLE;
            end else if (start) begin
               state_nxt_s = ST_CFG_DIV;
               sw_nxt_s    = 4'b0100;
               sdin_nxt_s  = {8'h00, DIV_DEF};
               under_clr_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CFG_DIV: begin
            if (stop) begin
               state_nxt_s = ST_STOP;
               sw_nxt_s    = 4'b1000;
               flush_s     = 1'b1;
            end else begin
               state_nxt_s = ST_CFG_CTL;
               sw_nxt_s    = 4'b1000;
               sdin_nxt_s  = {10'h000, CTRL_DEF};
            end
         end
         ST_CFG_CTL: begin
            if (stop) begin
               state_nxt_s = ST_STOP;
               sw_nxt_s    = 4'b1000;
               flush_s     = 1'b1;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               // stop pre-empts any right write still owed
               state_nxt_s = ST_STOP;
               sw_nxt_s    = 4'b1000;
               flush_s     = 1'b1;
            end else if (rpend_r) begin
               sw_nxt_s     = 4'b0010;
               sdin_nxt_s   = right_r;
               slot_q_nxt_s = slot_s | slot_q_r;
            end else if (slot_s || slot_q_r) begin
               if (!fifo_empty_s) begin
                  pop_s       = 1'b1;
                  sw_nxt_s    = 4'b0001;
                  sdin_nxt_s  = rd_data_s[31:16];
                  right_nxt_s = rd_data_s[15:0];
                  rpend_nxt_s = 1'b1;
               end else begin
                  under_set_s = 1'b1;
`ifdef BUTCH_I2S_SCHED_MUTE_EN
                  sw_nxt_s    = 4'b0001;
                  sdin_nxt_s  = 16'h0000;
                  right_nxt_s = 16'h0000;
                  rpend_nxt_s = 1'b1;
`endif
               end
            end else begin
               slot_q_nxt_s = slot_q_r;
            end
         end
         ST_STOP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and registered scheduler write-port drive.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         state_r  <= ST_IDLE;
         sw_r     <= 4'b0000;
         sdin_r   <= 16'h0000;
         right_r  <= 16'h0000;
         rpend_r  <= 1'b0;
         slot_q_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         sw_r     <= sw_nxt_s;
         sdin_r   <= sdin_nxt_s;
         right_r  <= right_nxt_s;
         rpend_r  <= rpend_nxt_s;
         slot_q_r <= slot_q_nxt_s;
      end
   end

   // Sticky underrun, cleared only by an accepted start.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         underrun_r <= 1'b0;
      end else if (under_clr_s) begin
         underrun_r <= 1'b0;
      end else if (under_set_s) begin
         underrun_r <= 1'b1;
      end else begin
         underrun_r <= underrun_r;
      end
   end

   // FIFO pointers and occupancy; flush empties it and drops a same-cycle push.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else if (flush_s) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // FIFO storage, data only.
   always_ff @(posedge sys_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= src_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // CPU writes pass straight through in cycles the scheduler leaves free.
   // resetl gates the pass-through so reset forces the port quiet at once.
   assign sched_act_s = |sw_r;
   assign cpu_acc_s   = cpu_wr & ~sched_act_s & resetl;
   assign cpu_busy    = cpu_wr & sched_act_s;

   assign i2s1w   = sw_r[0] | (cpu_acc_s & (cpu_sel == 2'd0));
   assign i2s2w   = sw_r[1] | (cpu_acc_s & (cpu_sel == 2'd1));
   assign i2s3w   = sw_r[2] | (cpu_acc_s & (cpu_sel == 2'd2));
   assign i2s4w   = sw_r[3] | (cpu_acc_s & (cpu_sel == 2'd3));
   assign i2s_din = sched_act_s ? sdin_r : (cpu_acc_s ? cpu_din : 16'h0000);

   assign src_ready = ~fifo_full_s;
   assign level     = level_r;
   assign underrun  = underrun_r;
   assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_butch_i2s_sched.sv
// Testbench for butch_i2s_sched: random frames, slots and CPU writes against a
// queue-based model; expected register writes go to a scoreboard that a
// separate monitor drains whenever a write strobe is seen.
module tb_butch_i2s_sched;

   logic        sys_clk = 1'b0;
   logic        resetl, start, stop, src_valid, src_ready;
   logic [31:0] src_data;
   logic        cpu_wr, cpu_busy;
   logic [1:0]  cpu_sel;
   logic [15:0] cpu_din, i2s_din;
   logic        wsout, i2s1w, i2s2w, i2s3w, i2s4w, underrun, busy;
   logic [3:0]  level;

   butch_i2s_sched dut (
      .sys_clk(sys_clk), .resetl(resetl), .start(start), .stop(stop),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .cpu_wr(cpu_wr), .cpu_sel(cpu_sel), .cpu_din(cpu_din), .cpu_busy(cpu_busy),
      .wsout(wsout), .i2s_din(i2s_din), .i2s1w(i2s1w), .i2s2w(i2s2w),
      .i2s3w(i2s3w), .i2s4w(i2s4w), .level(level), .underrun(underrun), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct { int port; int din; int at; } wr_t;
   wr_t         exp_q[$];
   logic [31:0] fq[$];          // model FIFO contents
   bit          m_run;          // model: sequencer out of IDLE and streaming
   bit          m_under;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   localparam int RST_VEC = 28'h040_0000;   // only src_ready high

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s got %h want %h (cyc %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic int out_vec();
      return int'({i2s1w, i2s2w, i2s3w, i2s4w, cpu_busy, src_ready, underrun, busy, level, i2s_din});
   endfunction

   // Scoreboard monitor: every strobe cycle must match the oldest expected write.
   logic [3:0] mon_v;
   int         mon_p;
   wr_t        mon_e;
   always @(negedge sys_clk) begin
      mon_v = {i2s4w, i2s3w, i2s2w, i2s1w};
      if (mon_v != 4'b0000) begin
         mon_p = (mon_v == 4'b0001) ? 1 : (mon_v == 4'b0010) ? 2 :
                 (mon_v == 4'b0100) ? 3 : (mon_v == 4'b1000) ? 4 : 0;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected got strobes=%b din=%h cyc=%0d want none", mon_v, i2s_din, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_p != mon_e.port || int'(i2s_din) != mon_e.din || cyc != mon_e.at) begin
               errors++;
               $display("FAIL wr got port=%0d din=%h cyc=%0d want port=%0d din=%h cyc=%0d",
                        mon_p, i2s_din, cyc, mon_e.port, mon_e.din, mon_e.at);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic exp_wr(input int port, input int din, input int at);
      wr_t e;
      e.port = port; e.din = din; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic do_start();
      int at;
      at = cyc;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      if (!m_run) begin
         exp_wr(3, 16'h0008, at + 1);
         exp_wr(4, 16'h0005, at + 2);
         m_under = 1'b0;
         m_run   = 1'b1;
      end
      tick(2);
      chk("busy_run", int'(busy), 1);
      chk("underrun_start", int'(underrun), int'(m_under));
   endtask

   task automatic do_push(input logic [31:0] d);
      chk("src_ready", int'(src_ready), int'(fq.size() < 8));
      src_valid = 1'b1;
      src_data  = d;
      if (fq.size() < 8) fq.push_back(d);
      tick(1);
      src_valid = 1'b0;
      chk("level_push", int'(level), fq.size());
   endtask

   // One word-select rising edge; optionally a source push lands on the pop edge.
   task automatic do_slot(input bit with_push, input logic [31:0] d);
      int at;
      bit rdy;
      logic [31:0] f;
      at = cyc;
      wsout = 1'b1;
      tick(2);
      rdy = (fq.size() < 8);
      if (with_push) begin
         src_valid = 1'b1;
         src_data  = d;
      end
      if (m_run) begin
         if (fq.size() > 0) begin
            f = fq.pop_front();
            exp_wr(1, int'(f[31:16]), at + 3);
            exp_wr(2, int'(f[15:0]), at + 4);
         end else begin
            m_under = 1'b1;
`ifdef BUTCH_I2S_SCHED_MUTE_EN
            exp_wr(1, 0, at + 3);
            exp_wr(2, 0, at + 4);
`endif
         end
      end
      if (with_push && rdy) fq.push_back(d);
      tick(1);
      src_valid = 1'b0;
      chk("level_slot", int'(level), fq.size());
      tick(3);
      wsout = 1'b0;
      tick(3);
      chk("underrun", int'(underrun), int'(m_under));
   endtask

   // CPU write held until accepted; exp_at is the model's acceptance cycle.
   task automatic do_cpu(input logic [1:0] sel, input logic [15:0] d, input int exp_at);
      cpu_wr  = 1'b1;
      cpu_sel = sel;
      cpu_din = d;
      exp_wr(int'(sel) + 1, int'(d), exp_at);
      for (int k = 0; k < 8; k++) begin
         @(negedge sys_clk);
         chk("cpu_busy", int'(cpu_busy), int'(cyc < exp_at));
         if (!cpu_busy) break;
         if (k == 7) begin
            checks++; errors++;
            $display("FAIL cpu_accept got busy after 8 cycles want accepted");
         end
      end
      @(posedge sys_clk);
      #1;
      cpu_wr = 1'b0;
   endtask

   task automatic do_stop();
      int at;
      at = cyc;
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      if (m_run) exp_wr(4, 0, at + 1);
      m_run = 1'b0;
      fq.delete();
      chk("level_flush", int'(level), 0);
      tick(1);
      chk("busy_idle", int'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      int at;
      logic [31:0] r;
      resetl = 1'b0; start = 1'b0; stop = 1'b0; src_valid = 1'b0; src_data = 32'h0;
      cpu_wr = 1'b0; cpu_sel = 2'd0; cpu_din = 16'h0; wsout = 1'b0;
      m_run = 1'b0; m_under = 1'b0;
      tick(3);
      chk("reset_outputs", out_vec(), RST_VEC);
      resetl = 1'b1;
      tick(2);
      chk("idle_outputs", out_vec(), RST_VEC);

      // start and stop together in IDLE: stop wins, nothing written
      start = 1'b1; stop = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b0;
      tick(2);
      chk("startstop_idle", int'(busy), 0);

      // frame slot while idle must not pop
      do_push(32'h1234ABCD);
      do_slot(1'b0, 32'h0);

      do_start();
      do_start();                 // ignored while running
      do_slot(1'b0, 32'h0);        // pops 1234/ABCD
      do_slot(1'b0, 32'h0);        // empty -> underrun

      // CPU left write colliding with the scheduler's left/right pair
      do_push($urandom);
      at = cyc;
      wsout = 1'b1;
      r = fq.pop_front();
      exp_wr(1, int'(r[31:16]), at + 3);
      exp_wr(2, int'(r[15:0]), at + 4);
      tick(3);
      do_cpu(2'd0, 16'h5A5A, at + 5);
      wsout = 1'b0;
      tick(3);
      chk("level_after_coll", int'(level), fq.size());

      // randomized mix of pushes, slots and idle-port CPU writes
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0: do_push($urandom);
            1: do_slot(1'b0, 32'h0);
            default: do_cpu(2'($urandom_range(0, 3)), 16'($urandom), cyc);
         endcase
      end

      // fill to full, then push+pop on the same edge (blocked when full, kept otherwise)
      while (fq.size() < 8) do_push($urandom);
      chk("full_level", int'(level), 8);
      chk("full_ready", int'(src_ready), 0);
      do_push($urandom);
      do_slot(1'b1, $urandom);
      do_slot(1'b1, $urandom);
      chk("pushpop_level", int'(level), 7);

      // stop with five frames queued
      while (fq.size() > 5) do_slot(1'b0, 32'h0);
      chk("five_queued", int'(level), 5);
      do_stop();
      do_slot(1'b0, 32'h0);        // idle again: slot ignored

      // stop during divider configuration
      at = cyc;
      start = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b1;
      exp_wr(3, 16'h0008, at + 1);
      exp_wr(4, 0, at + 2);
      m_under = 1'b0;
      tick(1);
      stop = 1'b0;
      tick(2);
      chk("stop_cfg_busy", int'(busy), 0);
      chk("stop_cfg_under", int'(underrun), 0);

      // asynchronous reset in the middle of a left write
      do_start();
      do_push($urandom);
      wsout = 1'b1;
      tick(3);
      #1;
      resetl = 1'b0;
      fq.delete();
      m_run = 1'b0;
      m_under = 1'b0;
      @(negedge sys_clk);
      chk("reset_midrun", out_vec(), RST_VEC);
      wsout = 1'b0;
      tick(2);
      resetl = 1'b1;
      tick(3);
      chk("post_reset", out_vec(), RST_VEC);

      tick(4);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
